// File: rtl/nios2_debug_cmd_sync.sv
// Brings JTAG update-IR/update-DR strobes into clk, latches the debug command and pulses per-channel action lines.
// Latency: capture visible SYNC_STAGES+2 clk edges after vs_udr is first sampled high.
// Backpressure: command is held until cmd_ready; a new command arriving while held is dropped and flags overrun.
module nios2_debug_cmd_sync #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    localparam int N          = 2**IR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vs_uir,
    input  logic              vs_udr,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [DATA_W-1:0] sr,
    input  logic              cmd_ready,
    input  logic              clear_overrun,
    output logic [DATA_W-1:0] jdo,
    output logic [IR_W-1:0]   cmd_ir,
    output logic              cmd_valid,
    output logic [N-1:0]      take_action,
    output logic [N-1:0]      take_no_action,
    output logic              overrun,
    output logic [CNT_W-1:0]  cmd_count
);

    logic [SYNC_STAGES-1:0] uir_sync;
    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] live;
    logic                   uir_dly;
    logic                   udr_dly;
    logic                   uir_armed;
    logic                   udr_armed;
    logic                   uir_edge;
    logic                   udr_edge;
    logic [IR_W-1:0]        ir_smp;
    logic [IR_W-1:0]        ir_q;
    logic                   capture;
    logic                   drop;
    logic [N-1:0]           ir_onehot;

    assign capture   = udr_edge && (!cmd_valid || cmd_ready);
    assign drop      = udr_edge && cmd_valid && !cmd_ready;
    assign ir_onehot = {{(N-1){1'b0}}, 1'b1} << ir_q;

    // 'live' tracks which sync stages hold real post-reset samples; a strobe
    // only arms once a genuine low sample has reached the end of the chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uir_sync  <= '0;
            udr_sync  <= '0;
            live      <= '0;
            uir_dly   <= 1'b0;
            udr_dly   <= 1'b0;
            uir_armed <= 1'b0;
            udr_armed <= 1'b0;
            uir_edge  <= 1'b0;
            udr_edge  <= 1'b0;
            ir_smp    <= '0;
        end else begin
            uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            live      <= {live[SYNC_STAGES-2:0], 1'b1};
            uir_dly   <= uir_sync[SYNC_STAGES-1];
            udr_dly   <= udr_sync[SYNC_STAGES-1];
            uir_armed <= uir_armed | (live[SYNC_STAGES-1] & ~uir_sync[SYNC_STAGES-1]);
            udr_armed <= udr_armed | (live[SYNC_STAGES-1] & ~udr_sync[SYNC_STAGES-1]);
            uir_edge  <= uir_sync[SYNC_STAGES-1] & ~uir_dly & uir_armed;
            udr_edge  <= udr_sync[SYNC_STAGES-1] & ~udr_dly & udr_armed;
            ir_smp    <= ir_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jdo            <= '0;
            cmd_ir         <= '0;
            ir_q           <= '0;
            cmd_valid      <= 1'b0;
            take_action    <= '0;
            take_no_action <= '0;
            overrun        <= 1'b0;
            cmd_count      <= '0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            if (capture) begin
                jdo       <= sr;
                cmd_ir    <= ir_q;
                cmd_valid <= 1'b1;
                cmd_count <= cmd_count + CNT_W'(1);
                if (sr[DATA_W-1]) take_action    <= ir_onehot;
                else              take_no_action <= ir_onehot;
            end else if (cmd_ready) begin
                cmd_valid <= 1'b0;
            end
            if (drop)               overrun <= 1'b1;
            else if (clear_overrun) overrun <= 1'b0;
            // Same-cycle capture above still sees the previous ir_q.
            if (uir_edge) ir_q <= ir_smp;
        end
    end

endmodule

// File: tb/tb_nios2_debug_cmd_sync.sv
// Bench for nios2_debug_cmd_sync: directed literal scenarios followed by randomized strobes,
// all checked every cycle against a history-based behavioural model.
module tb_nios2_debug_cmd_sync;

    localparam int DW = 38;
    localparam int S  = 2;
    localparam int DEPTH = 8192;

    logic          clk;
    logic          reset;
    logic          vs_uir;
    logic          vs_udr;
    logic [1:0]    ir_in;
    logic [DW-1:0] sr;
    logic          cmd_ready;
    logic          clear_overrun;

    logic [DW-1:0] jdo;
    logic [1:0]    cmd_ir;
    logic          cmd_valid;
    logic [3:0]    take_action;
    logic [3:0]    take_no_action;
    logic          overrun;
    logic [15:0]   cmd_count;

    logic [DW-1:0] jdo_b;
    logic [1:0]    cmd_ir_b;
    logic          cmd_valid_b;
    logic [3:0]    take_action_b;
    logic [3:0]    take_no_action_b;
    logic          overrun_b;
    logic [3:0]    cmd_count_b;

    nios2_debug_cmd_sync dut (
        .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in), .sr(sr),
        .cmd_ready(cmd_ready), .clear_overrun(clear_overrun), .jdo(jdo), .cmd_ir(cmd_ir),
        .cmd_valid(cmd_valid), .take_action(take_action), .take_no_action(take_no_action),
        .overrun(overrun), .cmd_count(cmd_count)
    );

    nios2_debug_cmd_sync #(.CNT_W(4)) dut_w4 (
        .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in), .sr(sr),
        .cmd_ready(cmd_ready), .clear_overrun(clear_overrun), .jdo(jdo_b), .cmd_ir(cmd_ir_b),
        .cmd_valid(cmd_valid_b), .take_action(take_action_b), .take_no_action(take_no_action_b),
        .overrun(overrun_b), .cmd_count(cmd_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Input history, one entry per rising clk edge.
    bit            hu   [DEPTH];
    bit            hd   [DEPTH];
    bit            hrst [DEPTH];
    bit            hrdy [DEPTH];
    bit            hclr [DEPTH];
    logic [1:0]    hir  [DEPTH];
    logic [DW-1:0] hsr  [DEPTH];

    int            rst_idx = -1;
    logic [DW-1:0] m_jdo;
    logic [1:0]    m_ir;
    logic [1:0]    m_irq;
    bit            m_valid;
    bit            m_ovr;
    logic [3:0]    m_ta;
    logic [3:0]    m_tna;
    int            m_cnt;

    // A strobe edge at sample k: high at k, low at k-1, and k-1 taken after the last reset.
    function automatic bit edge_at(input int k, input bit is_udr);
        if (k < 1 || k - 1 <= rst_idx) return 1'b0;
        if (is_udr) return hd[k] && !hd[k-1];
        return hu[k] && !hu[k-1];
    endfunction

    task automatic model_step(input int t);
        bit de, ue, drop;
        m_ta  = 4'b0;
        m_tna = 4'b0;
        if (hrst[t]) begin
            rst_idx = t;
            m_jdo = '0; m_ir = '0; m_irq = '0; m_valid = 0; m_ovr = 0; m_cnt = 0;
        end else begin
            de = edge_at(t - S - 1, 1'b1);
            ue = edge_at(t - S - 1, 1'b0);
            drop = de && m_valid && !hrdy[t];
            if (de && !drop) begin
                m_jdo   = hsr[t];
                m_ir    = m_irq;
                m_valid = 1;
                m_cnt   = (m_cnt + 1) % 65536;
                if (hsr[t][DW-1]) m_ta  = 4'b0001 << m_irq;
                else              m_tna = 4'b0001 << m_irq;
            end else if (m_valid && hrdy[t]) begin
                m_valid = 0;
            end
            if (drop)         m_ovr = 1;
            else if (hclr[t]) m_ovr = 0;
            if (ue) m_irq = hir[t - S - 1];
        end
    endtask

    initial begin
        int t = 0;
        forever begin
            @(posedge clk);
            if (t < DEPTH) begin
                hu[t] = vs_uir; hd[t] = vs_udr; hrst[t] = reset; hrdy[t] = cmd_ready;
                hclr[t] = clear_overrun; hir[t] = ir_in; hsr[t] = sr;
                #3;
                model_step(t);
                chk("jdo", 64'(jdo), 64'(m_jdo));
                chk("cmd_ir", 64'(cmd_ir), 64'(m_ir));
                chk("cmd_valid", 64'(cmd_valid), 64'(m_valid));
                chk("take_action", 64'(take_action), 64'(m_ta));
                chk("take_no_action", 64'(take_no_action), 64'(m_tna));
                chk("overrun", 64'(overrun), 64'(m_ovr));
                chk("cmd_count", 64'(cmd_count), 64'(m_cnt));
                chk("cmd_count_w4", 64'(cmd_count_b), 64'(m_cnt % 16));
                chk("take_action_w4", 64'(take_action_b), 64'(m_ta));
                t++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit u, input bit d);
        @(negedge clk);
        if (u) vs_uir = 1'b1;
        if (d) vs_udr = 1'b1;
        @(negedge clk);
        vs_uir = 1'b0;
        vs_udr = 1'b0;
    endtask

    // Returns just after the edge where a pulse() capture becomes visible.
    task automatic after_cap;
        repeat (3) @(posedge clk);
        #4;
    endtask

    initial begin
        int uir_low, udr_low, rst_hold;
        bit nu, nd;
        reset = 1'b1; vs_uir = 0; vs_udr = 0; ir_in = 0; sr = '0; cmd_ready = 0; clear_overrun = 0;
        idle(3);
        chk("rst_jdo", 64'(jdo), 64'h0);
        chk("rst_valid", 64'(cmd_valid), 64'h0);
        chk("rst_count", 64'(cmd_count), 64'h0);
        chk("rst_overrun", 64'(overrun), 64'h0);
        reset = 1'b0;
        idle(4);

        ir_in = 2'd2; pulse(1, 0); idle(6);
        sr = 38'h20_0000_00AB; cmd_ready = 1; pulse(0, 1); after_cap;
        chk("act_jdo", 64'(jdo), 64'h20_0000_00AB);
        chk("act_ir", 64'(cmd_ir), 64'd2);
        chk("act_pulse", 64'(take_action), 64'b0100);
        chk("act_nopulse", 64'(take_no_action), 64'b0);
        chk("act_count", 64'(cmd_count), 64'd1);
        chk("act_valid", 64'(cmd_valid), 64'd1);
        @(posedge clk); #4;
        chk("act_pulse_end", 64'(take_action), 64'b0);
        chk("act_valid_end", 64'(cmd_valid), 64'd0);

        idle(3); sr = 38'h0F_1234_5678; pulse(0, 1); after_cap;
        chk("noact_pulse", 64'(take_no_action), 64'b0100);
        chk("noact_act", 64'(take_action), 64'b0);
        chk("noact_count", 64'(cmd_count), 64'd2);

        idle(3); cmd_ready = 0; sr = 38'h25_5555_AAAA; pulse(0, 1); after_cap;
        chk("hold_count", 64'(cmd_count), 64'd3);
        idle(3); sr = 38'h3F_FFFF_0000; pulse(0, 1); after_cap;
        chk("drop_overrun", 64'(overrun), 64'd1);
        chk("drop_jdo", 64'(jdo), 64'h25_5555_AAAA);
        chk("drop_count", 64'(cmd_count), 64'd3);
        chk("drop_nopulse", 64'(take_action), 64'b0);
        @(negedge clk); clear_overrun = 1;
        @(negedge clk); clear_overrun = 0;
        chk("clear_overrun", 64'(overrun), 64'd0);
        cmd_ready = 1; idle(2);

        ir_in = 2'd1; pulse(1, 0); idle(6);
        ir_in = 2'd3; sr = 38'h30_0000_0001; pulse(1, 1); after_cap;
        chk("same_edge_pulse", 64'(take_action), 64'b0010);
        chk("same_edge_ir", 64'(cmd_ir), 64'd1);
        idle(4); pulse(0, 1); after_cap;
        chk("next_ir", 64'(cmd_ir), 64'd3);
        chk("next_pulse", 64'(take_action), 64'b1000);
        chk("next_count", 64'(cmd_count), 64'd5);

        @(negedge clk); vs_udr = 1; idle(20); vs_udr = 0; idle(4);
        chk("held_single", 64'(cmd_count), 64'd6);

        cmd_ready = 0; pulse(0, 1); reset = 1; idle(2); reset = 0; idle(8);
        chk("rst_sync_valid", 64'(cmd_valid), 64'd0);
        chk("rst_sync_count", 64'(cmd_count), 64'd0);

        @(negedge clk); vs_udr = 1; idle(2); reset = 1; idle(2); reset = 0; idle(10);
        chk("held_rst_valid", 64'(cmd_valid), 64'd0);
        vs_udr = 0; idle(4); pulse(0, 1); after_cap;
        chk("rearm_valid", 64'(cmd_valid), 64'd1);
        chk("rearm_count", 64'(cmd_count), 64'd1);

        @(negedge clk); reset = 1; idle(2); reset = 0; cmd_ready = 1; idle(3);
        for (int i = 0; i < 17; i++) begin
            sr = DW'($urandom); pulse(0, 1); idle(4);
        end
        chk("wrap_w4", 64'(cmd_count_b), 64'd1);
        chk("wrap_w16", 64'(cmd_count), 64'd17);

        uir_low = 0; udr_low = 0; rst_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) reset = 0;
            end else if ($urandom_range(0, 599) == 0) begin
                reset = 1; rst_hold = 2;
            end
            nu = ($urandom_range(0, 4) == 0) ? !vs_uir : vs_uir;
            nd = ($urandom_range(0, 2) == 0) ? !vs_udr : vs_udr;
            if (!vs_uir && !nu && uir_low >= S + 3) ir_in = 2'($urandom);
            if (!vs_udr && !nd && udr_low >= S + 3) sr = {6'($urandom), 32'($urandom)};
            uir_low = vs_uir ? 0 : uir_low + 1;
            udr_low = vs_udr ? 0 : udr_low + 1;
            vs_uir = nu;
            vs_udr = nd;
            cmd_ready = ($urandom_range(0, 1) == 1);
            clear_overrun = ($urandom_range(0, 9) == 0);
        end
        reset = 0; vs_uir = 0; vs_udr = 0; clear_overrun = 0;
        idle(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios2_debug_cmd_sync.md
NIOS2_DEBUG_CMD_SYNC -- requirements
Module: nios2_debug_cmd_sync

Interface
REQ-001 SHALL have parameter DATA_W, default 38, debug data register width (jdo/sr width, 8..64).
REQ-002 SHALL have parameter IR_W, default 2, instruction register width; command channel count N = 2**IR_W.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for JTAG strobes (2..4).
REQ-004 SHALL have parameter CNT_W, default 16, accepted-command counter width.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 vs_uir  input  1  update-IR strobe from TCK domain, asynchronous to clk.
REQ-009 vs_udr  input  1  update-DR strobe from TCK domain, asynchronous to clk.
REQ-010 ir_in  input  IR_W  instruction value, stable while vs_uir high.
REQ-011 sr  input  DATA_W  shifted data, stable from vs_udr rise until the next capture-DR.
REQ-012 cmd_ready  input  1  consumer accepts the held command this cycle.
REQ-013 clear_overrun  input  1  synchronous clear of overrun flag.
REQ-014 jdo  output  DATA_W  captured data register.
REQ-015 cmd_ir  output  IR_W  instruction associated with jdo.
REQ-016 cmd_valid  output  1  a command is held awaiting cmd_ready.
REQ-017 take_action  output  N  one-hot, one-cycle pulse: command with action bit set.
REQ-018 take_no_action  output  N  one-hot, one-cycle pulse: command with action bit clear.
REQ-019 overrun  output  1  sticky: a command was dropped.
REQ-020 cmd_count  output  CNT_W  number of commands captured since reset.

Function
REQ-021 vs_uir and vs_udr SHALL each pass through SYNC_STAGES flops plus one delay flop; rising edge = last sync stage high and delay flop low.
REQ-022 On a vs_uir edge, ir_q SHALL load ir_in from a register sampled in the same synchroniser cycle as the edge flag.
REQ-023 On a vs_udr edge with cmd_valid low or cmd_ready high, the block SHALL capture: jdo <= sr, cmd_ir <= ir_q, cmd_valid <= 1, cmd_count += 1.
REQ-024 Capture SHALL be visible exactly SYNC_STAGES+2 clk rising edges after the first edge sampling vs_udr high.
REQ-025 Same cycle as capture, take_action[ir_q] SHALL pulse if sr[DATA_W-1] = 1, otherwise take_no_action[ir_q]; all other bits 0; pulse width exactly one cycle.
REQ-026 cmd_valid SHALL clear on the cycle after cmd_valid && cmd_ready unless a new capture occurs that cycle, in which case it stays 1 with new data.
REQ-027 On a vs_udr edge with cmd_valid high and cmd_ready low, the command SHALL be dropped: jdo/cmd_ir/cmd_count unchanged, no pulse, overrun <= 1.
REQ-028 overrun SHALL clear only on clear_overrun=1 or reset; a simultaneous drop and clear_overrun SHALL leave overrun = 1.
REQ-029 Simultaneous uir and udr edges in one cycle: capture SHALL use the old ir_q; ir_q updates afterwards.
REQ-030 cmd_count SHALL wrap from 2**CNT_W-1 to 0 without flagging.
REQ-031 A strobe held high SHALL produce only one edge; re-arm requires a low sample through the chain.

Reset
REQ-032 On reset: jdo = 0, cmd_ir = 0, ir_q = 0, cmd_valid = 0, take_action = 0, take_no_action = 0, overrun = 0, cmd_count = 0, all synchroniser and delay flops = 0.
REQ-033 Reset asserted mid-capture SHALL discard any in-flight edge; a strobe still high at deassertion SHALL NOT produce an edge until it goes low and high again.

Verification
REQ-034 Defaults; ir_in=2 with vs_uir pulse, then sr=38'h20_0000_00AB with vs_udr pulse, cmd_ready=1 -> 4 cycles after udr sample: jdo=38'h20_0000_00AB, cmd_ir=2, take_action=4'b0100 for 1 cycle, cmd_count=1.
REQ-035 Same with sr[37]=0 -> take_no_action=4'b0100, take_action=0.
REQ-036 cmd_ready=0, two udr pulses -> second dropped, overrun=1, jdo holds first data, cmd_count=1; clear_overrun -> overrun=0.
REQ-037 vs_uir and vs_udr rising on the same clk edge with ir_q=1, ir_in=3 -> pulse on bit 1, then cmd_ir=3 on next command.
REQ-038 CNT_W=4, 17 accepted commands -> cmd_count=1; vs_udr held high 20 cycles -> single capture; reset during sync -> no pulse.
